// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache line-transfer engine.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } xfer_state_t;

  // Number of byte-offset bits inside one word.
  function automatic int unsigned byte_bits(int unsigned word_size);
    return $clog2(word_size / 8);
  endfunction

  // Clear the low_bits least significant bits (line offset) of an address.
  function automatic logic [63:0] line_base(logic [63:0] addr, int unsigned low_bits);
    logic [63:0] mask;
    mask = (64'd1 << low_bits) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/cache_line_buffer.sv
// Line buffer: WORDS_PER_LINE x WORD_SIZE registers, one write port, flat read-out.
// Not reset; contents are only meaningful after a fill.
module cache_line_buffer
  import cache_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned WORDS_PER_LINE = 8,
  localparam int unsigned LineBits      = $clog2(WORDS_PER_LINE)
) (
  input  logic                                clk_i,
  input  logic                                we_i,
  input  logic [LineBits-1:0]                 idx_i,
  input  logic [WORD_SIZE-1:0]                wdata_i,
  output logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_o
);

  logic [WORD_SIZE-1:0] mem_q [WORDS_PER_LINE];

  // Single write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Flatten the array, word 0 in the LSBs.
  always_comb begin
    line_o = '0;
    for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
      line_o[i*WORD_SIZE +: WORD_SIZE] = mem_q[i];
    end
  end

endmodule

// File: rtl/cache_line_xfer.sv
// Line-transfer engine between a cache data array and word-wide memory.
// Fills a line, writes back a line, or evicts-then-fills on one command.
// Build option CACHE_CRIT_WORD_FIRST_EN: fill starts at the addressed word and wraps;
// otherwise fills always start at word 0.
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter int unsigned ADDR_SIZE      = 32
) (
  input  logic                                clk,
  input  logic                                clr_n,
  input  logic                                start_fill,
  input  logic                                start_wb,
  input  logic [ADDR_SIZE-1:0]                line_addr_i,
  input  logic [ADDR_SIZE-1:0]                wb_addr_i,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] wb_line_i,
  output logic                                busy,
  output logic                                done,
  output logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_o,
  output logic                                crit_valid_o,
  output logic [WORD_SIZE-1:0]                crit_data_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [ADDR_SIZE-1:0]                mem_addr_o,
  output logic [WORD_SIZE-1:0]                mem_wdata_o,
  input  logic                                mem_ack_i,
  input  logic [WORD_SIZE-1:0]                mem_rdata_i
);

  localparam int unsigned ByteBits = byte_bits(WORD_SIZE);
  localparam int unsigned LineBits = $clog2(WORDS_PER_LINE);
  localparam int unsigned LowBits  = LineBits + ByteBits;
  localparam int unsigned LineW    = WORD_SIZE * WORDS_PER_LINE;

  xfer_state_t          state_q, state_d;
  logic [LineBits:0]    beat_q, beat_d;
  logic                 pend_fill_q, pend_fill_d;
  logic [LineW-1:0]     wb_line_q, wb_line_d;
  logic [ADDR_SIZE-1:0] wb_base_q, wb_base_d;
  logic [ADDR_SIZE-1:0] fill_base_q, fill_base_d;
  logic [LineBits-1:0]  crit_off_q, crit_off_d;
  logic                 crit_valid_d;
  logic [WORD_SIZE-1:0] crit_data_d;

  logic [LineBits-1:0]  beat_idx, start_idx, fill_idx;
  logic                 beat_ack, last_beat, buf_we;

  function automatic logic [ADDR_SIZE-1:0] base_of(logic [ADDR_SIZE-1:0] addr);
    return ADDR_SIZE'(line_base(64'(addr), LowBits));
  endfunction

  assign beat_idx  = beat_q[LineBits-1:0];
`ifdef CACHE_CRIT_WORD_FIRST_EN
  assign start_idx = crit_off_q;
`else
  assign start_idx = '0;
`endif
  // Modulo-WORDS_PER_LINE wrap comes from the LineBits-wide sum.
  assign fill_idx  = start_idx + beat_idx;
  assign beat_ack  = mem_req_o & mem_ack_i;
  assign last_beat = (beat_q == (LineBits+1)'(WORDS_PER_LINE - 1));
  assign buf_we    = (state_q == FILL) && beat_ack;

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      pend_fill_q  <= 1'b0;
      wb_line_q    <= '0;
      wb_base_q    <= '0;
      fill_base_q  <= '0;
      crit_off_q   <= '0;
      crit_valid_o <= 1'b0;
      crit_data_o  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      pend_fill_q  <= pend_fill_d;
      wb_line_q    <= wb_line_d;
      wb_base_q    <= wb_base_d;
      fill_base_q  <= fill_base_d;
      crit_off_q   <= crit_off_d;
      crit_valid_o <= crit_valid_d;
      crit_data_o  <= crit_data_d;
    end
  end

  // Next-state: commands only accepted in IDLE; transfers end on the last ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_wb) begin
          state_d = WB;
        end else if (start_fill) begin
          state_d = FILL;
        end
      end
      WB:      if (beat_ack && last_beat) state_d = pend_fill_q ? FILL : DONE;
      FILL:    if (beat_ack && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture, beat counting and critical-word detection.
  always_comb begin
    beat_d      = beat_q;
    pend_fill_d = pend_fill_q;
    wb_line_d   = wb_line_q;
    wb_base_d   = wb_base_q;
    fill_base_d = fill_base_q;
    crit_off_d  = crit_off_q;
    if (beat_ack) beat_d = beat_q + 1'b1;
    // Every state change starts a fresh beat count (covers WB->FILL handover).
    if (state_d != state_q) beat_d = '0;
    if (state_q == IDLE) begin
      if (start_wb) begin
        wb_line_d   = wb_line_i;
        wb_base_d   = base_of(wb_addr_i);
        pend_fill_d = start_fill;
      end
      if (start_wb || start_fill) begin
        fill_base_d = base_of(line_addr_i);
        crit_off_d  = line_addr_i[ByteBits +: LineBits];
      end
    end
    if (state_q == WB && state_d == FILL) pend_fill_d = 1'b0;
    crit_valid_d = buf_we && (fill_idx == crit_off_q);
    crit_data_d  = crit_valid_d ? mem_rdata_i : '0;
  end

  // Outputs decoded from the current state and beat.
  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wb_base_q + (ADDR_SIZE'(beat_idx) << ByteBits);
        mem_wdata_o = wb_line_q[beat_idx*WORD_SIZE +: WORD_SIZE];
      end
      FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = fill_base_q + (ADDR_SIZE'(fill_idx) << ByteBits);
      end
      default: ;
    endcase
  end

  cache_line_buffer #(
    .WORD_SIZE      (WORD_SIZE),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_line_buffer (
    .clk_i   (clk),
    .we_i    (buf_we),
    .idx_i   (fill_idx),
    .wdata_i (mem_rdata_i),
    .line_o  (line_o)
  );

endmodule

// File: tb/tb_cache_line_xfer.sv
// Self-checking bench for cache_line_xfer (honours CACHE_CRIT_WORD_FIRST_EN if defined).
module tb_cache_line_xfer;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 8;
  localparam int unsigned A  = 32;
  localparam int unsigned LW = W * N;
  localparam logic [A-1:0] LMASK = A'(N * (W / 8) - 1);

  logic          clk = 1'b0;
  logic          clr_n = 1'b1;
  logic          start_fill = 1'b0, start_wb = 1'b0;
  logic [A-1:0]  line_addr_i = '0, wb_addr_i = '0;
  logic [LW-1:0] wb_line_i = '0;
  logic          busy, done, crit_valid_o, mem_req_o, mem_we_o;
  logic [LW-1:0] line_o;
  logic [W-1:0]  crit_data_o, mem_wdata_o;
  logic [A-1:0]  mem_addr_o;
  logic          mem_ack_i = 1'b0;
  logic [W-1:0]  mem_rdata_i = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] salt = 32'h0;

  always #5 clk = ~clk;

  cache_line_xfer #(
    .WORD_SIZE      (W),
    .WORDS_PER_LINE (N),
    .ADDR_SIZE      (A)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .start_fill   (start_fill),
    .start_wb     (start_wb),
    .line_addr_i  (line_addr_i),
    .wb_addr_i    (wb_addr_i),
    .wb_line_i    (wb_line_i),
    .busy         (busy),
    .done         (done),
    .line_o       (line_o),
    .crit_valid_o (crit_valid_o),
    .crit_data_o  (crit_data_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  // Memory contents model: a fixed function of the word address and a per-command salt.
  function automatic logic [W-1:0] mem_word(logic [A-1:0] a);
    return {a[15:0], ~a[15:0]} ^ salt;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command and act as memory until done; the model predicts every beat.
  task automatic run_cmd(input bit is_wb, input bit with_fill, input logic [A-1:0] laddr,
                         input logic [A-1:0] waddr, input logic [LW-1:0] wline,
                         input bit stall, input bit poke, input int exp_lat, input int exp_crit);
    logic [A-1:0]  exp_addr[$];
    logic [W-1:0]  exp_data[$];
    bit            exp_we[$];
    logic [A-1:0]  lbase, wbase, crit_addr, p_addr;
    logic [W-1:0]  p_wdata, crit_exp;
    logic [LW-1:0] exp_line;
    logic          p_we;
    bit            fill, held, crit_due;
    int            s, off, cyc, n_done, n_crit, beat;
    fill  = !is_wb || with_fill;
    lbase = laddr & ~LMASK;
    wbase = waddr & ~LMASK;
    off   = int'((laddr / (W / 8)) % N);
`ifdef CACHE_CRIT_WORD_FIRST_EN
    s = off;
`else
    s = 0;
`endif
    crit_addr = lbase + A'(off * (W / 8));
    if (is_wb) begin
      for (int k = 0; k < int'(N); k++) begin
        exp_addr.push_back(wbase + A'(k * (W / 8)));
        exp_data.push_back(wline[k*W +: W]);
        exp_we.push_back(1'b1);
      end
    end
    if (fill) begin
      for (int k = 0; k < int'(N); k++) begin
        logic [A-1:0] a;
        a = lbase + A'(((s + k) % N) * (W / 8));
        exp_addr.push_back(a);
        exp_data.push_back(mem_word(a));
        exp_we.push_back(1'b0);
      end
      for (int i = 0; i < int'(N); i++) exp_line[i*W +: W] = mem_word(lbase + A'(i * (W / 8)));
    end
    @(negedge clk);
    line_addr_i = laddr;
    wb_addr_i   = waddr;
    wb_line_i   = wline;
    start_wb    = is_wb;
    start_fill  = fill;
    @(negedge clk);
    start_wb = 1'b0;
    start_fill = 1'b0;
    cyc = 0; n_done = 0; n_crit = 0; beat = 0; held = 0; crit_due = 0;
    p_addr = '0; p_wdata = '0; p_we = 1'b0; crit_exp = '0;
    while (n_done == 0 && cyc < 400) begin
      cyc++;
      chk("busy_high", busy, 1'b1);
      chk("crit_valid", crit_valid_o, crit_due);
      if (crit_due) begin
        n_crit++;
        chk("crit_data", crit_data_o, crit_exp);
        if (exp_crit != 0) chk("crit_cycle", cyc, exp_crit);
      end
      crit_due = 0;
      if (held) begin
        chk("stall_addr", mem_addr_o, p_addr);
        chk("stall_we", mem_we_o, p_we);
        chk("stall_wdata", mem_wdata_o, p_wdata);
      end
      if (done) begin
        n_done++;
        chk("req_in_done", mem_req_o, 1'b0);
        if (exp_lat != 0) chk("latency", cyc, exp_lat);
      end
      mem_ack_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_rdata_i = $urandom;
      if (mem_req_o) begin
        if (beat < exp_addr.size()) begin
          chk("beat_addr", mem_addr_o, exp_addr[beat]);
          chk("beat_we", mem_we_o, exp_we[beat]);
          if (exp_we[beat]) chk("beat_wdata", mem_wdata_o, exp_data[beat]);
        end else begin
          chk("extra_beat", mem_req_o, 1'b0);
        end
        if (!mem_we_o) mem_rdata_i = mem_word(mem_addr_o);
        if (mem_ack_i) begin
          beat++;
          if (!mem_we_o && mem_addr_o == crit_addr) begin
            crit_due = 1;
            crit_exp = mem_word(mem_addr_o);
          end
        end
      end
      held    = mem_req_o && !mem_ack_i;
      p_addr  = mem_addr_o;
      p_we    = mem_we_o;
      p_wdata = mem_wdata_o;
      if (poke && cyc == 3) begin
        start_fill = 1'b1; start_wb = 1'b1;
        line_addr_i = ~laddr; wb_addr_i = ~waddr; wb_line_i = ~wline;
      end else begin
        start_fill = 1'b0; start_wb = 1'b0;
      end
      @(negedge clk);
    end
    mem_ack_i = 1'b0;
    if (n_done == 0) chk("done_timeout", done, 1'b1);
    chk("beat_count", beat, exp_addr.size());
    chk("crit_count", n_crit, fill);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_req", mem_req_o, 1'b0);
    if (fill) chk("line_o", line_o, exp_line);
  endtask

  typedef struct {
    bit          is_wb;
    bit          with_fill;
    logic [31:0] laddr;
    logic [31:0] waddr;
    bit          stall;
    bit          poke;
    int          exp_lat;
    int          exp_crit;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [LW-1:0] wl;
    tbl[0] = '{0, 0, 32'h0000_1234, 32'h0,         0, 0, 9,  7};
    tbl[1] = '{1, 1, 32'h0000_2008, 32'h8000_0040, 0, 0, 17, 12};
    tbl[2] = '{1, 0, 32'h5555_5555, 32'h8000_0044, 0, 0, 9,  0};
    tbl[3] = '{0, 0, 32'h0000_ABCF, 32'h0,         1, 0, 0,  0};
    tbl[4] = '{0, 0, 32'h0000_1234, 32'h0,         0, 1, 9,  7};
`ifdef CACHE_CRIT_WORD_FIRST_EN
    tbl[0].exp_crit = 2;
    tbl[1].exp_crit = 10;
    tbl[4].exp_crit = 2;
`endif

    // Reset values.
    #2 clr_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_addr", mem_addr_o, '0);
    chk("rst_wdata", mem_wdata_o, '0);
    chk("rst_crit_v", crit_valid_o, 1'b0);
    chk("rst_crit_d", crit_data_o, '0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    // Directed table.
    for (int t = 0; t < 5; t++) begin
      salt = $urandom;
      for (int k = 0; k < int'(N); k++) wl[k*W +: W] = $urandom;
      run_cmd(tbl[t].is_wb, tbl[t].with_fill, tbl[t].laddr, tbl[t].waddr, wl,
              tbl[t].stall, tbl[t].poke, tbl[t].exp_lat, tbl[t].exp_crit);
    end

    // Reset after the 3rd ack of a fill.
    salt = $urandom;
    @(negedge clk);
    line_addr_i = 32'h0000_1234;
    start_fill  = 1'b1;
    @(negedge clk);
    start_fill = 1'b0;
    mem_ack_i  = 1'b1;
    repeat (3) begin
      mem_rdata_i = mem_word(mem_addr_o);
      @(negedge clk);
    end
    mem_ack_i = 1'b0;
    clr_n     = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_req", mem_req_o, 1'b0);
    chk("mid_rst_we", mem_we_o, 1'b0);
    chk("mid_rst_addr", mem_addr_o, '0);
    chk("mid_rst_wdata", mem_wdata_o, '0);
    chk("mid_rst_crit_v", crit_valid_o, 1'b0);
    chk("mid_rst_crit_d", crit_data_o, '0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", done, 1'b0);
    end
    clr_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    salt = $urandom;
    run_cmd(0, 0, 32'h0000_1234, 32'h0, '0, 0, 0, 9, tbl[0].exp_crit);

    // Randomised commands with ~50% ack stalls.
    for (int r = 0; r < 20; r++) begin
      int kind;
      kind = $urandom_range(0, 2);
      salt = $urandom;
      for (int k = 0; k < int'(N); k++) wl[k*W +: W] = $urandom;
      run_cmd(kind != 0, kind == 2, $urandom, $urandom, wl, 1, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_line_xfer.md
# cache_line_xfer

Parametrised line-transfer engine between a cache data array and word-wide main memory. It fills a whole line from memory, or writes a whole line back to memory, one word per handshake. It supports evict-then-fill on a single command and optional critical-word-first fill ordering. It sits between the cache controller FSM and the memory port and replaces the counter-only line adapter with a self-sequencing, handshaked block.

## Interface
- WORD_SIZE, 32, bits per word; byte-addressed, so it must be a multiple of 8.
- WORDS_PER_LINE, 8, words per line; a power of two, ≥2.
- ADDR_SIZE, 32, address width.
- clk  in  1  rising-edge clock.
- clr_n  in  1  reset; asynchronous, active-low.
- start_fill  in  1  request a line fill of line_addr_i.
- start_wb  in  1  request a writeback of wb_line_i to wb_addr_i.
- line_addr_i  in  ADDR_SIZE  fill address; any byte within the line.
- wb_addr_i  in  ADDR_SIZE  writeback address; any byte within the line.
- wb_line_i  in  WORD_SIZE*WORDS_PER_LINE  victim line, flat; word 0 is in the LSBs.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the whole command completes.
- line_o  out  WORD_SIZE*WORDS_PER_LINE  filled line, flat.
- crit_valid_o  out  1  one-cycle pulse when the word addressed by line_addr_i arrives.
- crit_data_o  out  WORD_SIZE  that word; valid only while crit_valid_o is high.
- mem_req_o  out  1  beat request.
- mem_we_o  out  1  1 = write beat, 0 = read beat.
- mem_addr_o  out  ADDR_SIZE  beat address, word-aligned.
- mem_wdata_o  out  WORD_SIZE  write data.
- mem_ack_i  in  1  beat accepted. On a read it qualifies mem_rdata_i.
- mem_rdata_i  in  WORD_SIZE  read data.

## Operation
- Derived constants:
  - BYTE_BITS = $clog2(WORD_SIZE/8).
  - LINE_BITS = $clog2(WORDS_PER_LINE).
  - Line base = address with its low LINE_BITS+BYTE_BITS bits zeroed.
- FSM states: IDLE, WB, FILL, DONE.
- Command capture in IDLE:
  - Commands are sampled only in IDLE; starts in any other state are ignored.
  - start_wb → WB. wb_line_i, wb_addr_i and line_addr_i are all captured.
  - If start_fill is high in the same cycle, a pending-fill flag is set.
  - start_fill alone → FILL; line_addr_i is captured.
- WB state:
  - Beats issue in word order 0..WORDS_PER_LINE-1 with mem_we_o=1.
  - mem_addr_o = wb base + (beat<<BYTE_BITS).
  - mem_wdata_o = captured word [beat].
- FILL state:
  - mem_we_o=0.
  - Each acked mem_rdata_i is written into line buffer word [idx].
  - idx = (start + beat) mod WORDS_PER_LINE.
- After the last ack:
  - From WB: go to FILL if the pending-fill flag is set (flag cleared), else to DONE.
  - From FILL: go to DONE.
  - DONE → IDLE unconditionally.
- Beat counter: LINE_BITS+1 bits; reset to 0 on entry to WB and FILL. Word index arithmetic wraps modulo WORDS_PER_LINE.
- crit_valid_o fires on the ack whose idx equals the line_addr_i word offset. It fires exactly once per fill and never during WB.
- line_o is driven from the line buffer. It is stable from DONE until the next fill starts.

## Timing
- Reset values:
  - State IDLE; busy, done, mem_req_o, mem_we_o, crit_valid_o = 0.
  - mem_addr_o, mem_wdata_o, crit_data_o = 0.
  - Line buffer is not reset; line_o is undefined until the first fill.
- busy rises in the cycle after the accepted start and is high through DONE. done=1 only in DONE, with busy=1 in that same cycle.
- mem_req_o rises in the cycle after the accepted start. While mem_req_o=1 and mem_ack_i=0, mem_addr_o, mem_we_o and mem_wdata_o hold stable.
- The next beat follows an ack with no bubble: one beat per cycle maximum.
- The WB→FILL handover has no idle cycle; the first read beat follows the last write ack directly.
- Minimum command latency, start to done: WORDS_PER_LINE+1 cycles (WORDS_PER_LINE+WORDS_PER_LINE+1 for evict-then-fill).
- crit_valid_o and crit_data_o are registered: they appear in the cycle after the qualifying ack.
- mem_ack_i while mem_req_o=0 is ignored.
- clr_n low mid-transfer: immediate return to reset values. No done pulse is produced and the pending fill is dropped.

## Configuration
- CACHE_CRIT_WORD_FIRST_EN defined: fill starts at the word offset of line_addr_i and wraps.
- Not defined: fill always starts at word 0. crit_valid_o still pulses when the addressed word arrives.
- Writeback order is 0..N-1 in both builds.

## Structure
- Shared package cache_pkg holds:
  - the xfer_state_t enum (IDLE, WB, FILL, DONE);
  - the BYTE_BITS derivation;
  - the line_base(addr) function, parametrised by LINE_BITS+BYTE_BITS.
- One sub-module: cache_line_buffer, a WORDS_PER_LINE × WORD_SIZE register array with a single write port (we, idx, data) and a flat read-out.

## Test plan
- Reset, then start_fill with line_addr_i=0x0000_1234, macro off, 8×32-bit line, ack every cycle:
  - mem_addr_o reads 0x1220, 0x1224, …, 0x123C.
  - crit_valid_o pulses after the 6th ack with that word's data.
  - done arrives 9 cycles after start; line_o matches the memory model.
- Same fill with macro on:
  - Addresses 0x1234, 0x1238, 0x123C, 0x1220, …, 0x1230.
  - crit_valid_o pulses after the 1st ack.
- start_wb with start_fill in the same cycle (wb_addr_i=0x8000_0040):
  - 8 writes to 0x8000_0040..0x8000_005C carrying wb_line_i words 0..7.
  - Then 8 reads with no gap; exactly one done.
- Random mem_ack_i stalls (about 50%): mem_addr_o and mem_wdata_o are unchanged during stalls; final line_o is correct.
- start_fill pulsed while busy: ignored, and the in-flight transfer is unchanged.
- clr_n low after the 3rd ack: all outputs are 0 immediately with no done pulse. A new fill after release completes normally.
